// File: rtl/dma_timing_control_if.sv
// ============================================================================
// Module : dma_timing_control_if
// Brief  : Request/hold/bus-strobe bundle between the host side and the DMA
//          timing-and-control stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dma_timing_control_if;
  logic [3:0] DREQ;
  logic       HLDA;
  logic       CS_N;
  logic [7:0] commandReg;
  logic [7:0] xferType;
  logic [3:0] maskReg;
  logic       tc;

  logic       programCondition;
  logic       HRQ;
  logic [3:0] DACK;
  logic       AEN;
  logic       ADSTB;
  logic       MEMR_N;
  logic       MEMW_N;
  logic       IOR_N;
  logic       IOW_N;
  logic       EOP_N;
  logic       decrement;
  logic [1:0] activeChannel;

  modport master (
    output DREQ, HLDA, CS_N, commandReg, xferType, maskReg, tc,
    input  programCondition, HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N,
           IOR_N, IOW_N, EOP_N, decrement, activeChannel
  );

  modport slave (
    input  DREQ, HLDA, CS_N, commandReg, xferType, maskReg, tc,
    output programCondition, HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N,
           IOR_N, IOW_N, EOP_N, decrement, activeChannel
  );
endinterface

`default_nettype wire

// File: rtl/dma_timing_control.sv
// ============================================================================
// Module : dma_timing_control
// Brief  : 8237-style DMA timing and control: DREQ arbitration, HRQ/HLDA
//          handshake and single-transfer SI..S4 sequencing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dma_timing_control #(
  parameter int NUM_CH = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  dma_timing_control_if.slave  bus
);

  localparam logic [2:0] c_st_si = 3'd0;
  localparam logic [2:0] c_st_s0 = 3'd1;
  localparam logic [2:0] c_st_s1 = 3'd2;
  localparam logic [2:0] c_st_s2 = 3'd3;
  localparam logic [2:0] c_st_s3 = 3'd4;
  localparam logic [2:0] c_st_s4 = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [1:0]        r_chan;
  logic [1:0]        r_prio;
  logic [NUM_CH-1:0] w_elig;
  logic [1:0]        w_base;
  logic [1:0]        w_idx;
  logic [1:0]        w_winner;
  logic              w_any;
  logic [1:0]        w_type;
  logic              w_rd_mem;
  logic              w_rd_io;
  logic              w_unused_cmd;

  logic       r_hrq, r_aen, r_adstb, r_dec;
  logic       r_memr_n, r_memw_n, r_ior_n, r_iow_n, r_eop_n;
  logic [3:0] r_dack;

  assign w_elig       = bus.DREQ & ~bus.maskReg & {NUM_CH{~bus.commandReg[2]}};
  assign w_unused_cmd = ^{bus.commandReg[7:5], bus.commandReg[3], bus.commandReg[1:0]};

  // Scan from the lowest-priority offset down so the highest-priority hit wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = 2'd0;
    w_idx    = 2'd0;
    w_base   = bus.commandReg[4] ? r_prio : 2'd0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx = w_base + 2'(k);
      if (w_elig[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_type = 2'b00;
    case (r_chan)
      2'd0: w_type = bus.xferType[1:0];
      2'd1: w_type = bus.xferType[3:2];
      2'd2: w_type = bus.xferType[5:4];
      default: w_type = bus.xferType[7:6];
    endcase
  end

  assign w_rd_mem = (w_type == 2'b10);
  assign w_rd_io  = (w_type == 2'b01);

  always_comb begin
    w_next = c_st_si;
    case (r_state)
      c_st_si: w_next = w_any ? c_st_s0 : c_st_si;
      c_st_s0: begin
        if (!w_elig[r_chan])  w_next = c_st_si;
        else if (bus.HLDA)    w_next = c_st_s1;
        else                  w_next = c_st_s0;
      end
      c_st_s1: w_next = bus.HLDA ? c_st_s2 : c_st_si;
      c_st_s2: w_next = bus.HLDA ? c_st_s3 : c_st_si;
      c_st_s3: w_next = bus.HLDA ? c_st_s4 : c_st_si;
      default: w_next = c_st_si;
    endcase
  end

  // Outputs are registered from the next state so they are valid throughout the state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= c_st_si;
      r_chan   <= 2'd0;
      r_prio   <= 2'd0;
      r_hrq    <= 1'b0;
      r_aen    <= 1'b0;
      r_adstb  <= 1'b0;
      r_dack   <= 4'b0000;
      r_dec    <= 1'b0;
      r_memr_n <= 1'b1;
      r_memw_n <= 1'b1;
      r_ior_n  <= 1'b1;
      r_iow_n  <= 1'b1;
      r_eop_n  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == c_st_si && w_any) r_chan <= w_winner;
      if (r_state == c_st_s4)          r_prio <= r_chan + 2'd1;
      r_hrq    <= (w_next != c_st_si);
      r_aen    <= (w_next == c_st_s1) || (w_next == c_st_s2) ||
                  (w_next == c_st_s3) || (w_next == c_st_s4);
      r_adstb  <= (w_next == c_st_s1);
      r_dack   <= ((w_next == c_st_s2) || (w_next == c_st_s3) || (w_next == c_st_s4))
                  ? (4'b0001 << r_chan) : 4'b0000;
      r_memr_n <= !(((w_next == c_st_s2) || (w_next == c_st_s3)) && w_rd_mem);
      r_ior_n  <= !(((w_next == c_st_s2) || (w_next == c_st_s3)) && w_rd_io);
      r_memw_n <= !((w_next == c_st_s3) && w_rd_io);
      r_iow_n  <= !((w_next == c_st_s3) && w_rd_mem);
      r_dec    <= (w_next == c_st_s4);
      r_eop_n  <= !((w_next == c_st_s4) && bus.tc);
    end
  end

  assign bus.programCondition = !bus.CS_N & !bus.HLDA;
  assign bus.HRQ              = r_hrq;
  assign bus.DACK             = r_dack;
  assign bus.AEN              = r_aen;
  assign bus.ADSTB            = r_adstb;
  assign bus.MEMR_N           = r_memr_n;
  assign bus.MEMW_N           = r_memw_n;
  assign bus.IOR_N            = r_ior_n;
  assign bus.IOW_N            = r_iow_n;
  assign bus.EOP_N            = r_eop_n;
  assign bus.decrement        = r_dec;
  assign bus.activeChannel    = r_chan;

endmodule

`default_nettype wire

// File: tb/tb_dma_timing_control.sv
// ============================================================================
// Module : tb_dma_timing_control
// Brief  : Directed self-checking bench for dma_timing_control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dma_timing_control;

  logic clk;
  logic rst;
  logic auto_hlda;
  int   n_chk;
  int   n_err;

  dma_timing_control_if bus ();

  dma_timing_control #(.NUM_CH(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Host model returns HLDA a moment after it sees HRQ.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (auto_hlda) bus.HLDA = bus.HRQ;
  endtask

  // Follows one transfer from SI through S0..S4 back to SI.
  task automatic xfer(input logic [1:0] ch, input logic [1:0] typ, input logic tcv,
                      input logic drop);
    logic       rd_mem;
    logic       rd_io;
    logic [3:0] dk;
    rd_mem = (typ == 2'b10);
    rd_io  = (typ == 2'b01);
    dk     = 4'b0001 << ch;
    cyc();
    chk("s0_hrq", bus.HRQ, 1);
    chk("s0_chan", bus.activeChannel, ch);
    chk("s0_aen", bus.AEN, 0);
    cyc();
    chk("s1_aen", bus.AEN, 1);
    chk("s1_adstb", bus.ADSTB, 1);
    chk("s1_dack", bus.DACK, 0);
    cyc();
    chk("s2_dack", bus.DACK, dk);
    chk("s2_adstb", bus.ADSTB, 0);
    chk("s2_memr", bus.MEMR_N, !rd_mem);
    chk("s2_ior", bus.IOR_N, !rd_io);
    chk("s2_wr", {bus.MEMW_N, bus.IOW_N}, 2'b11);
    if (drop) bus.DREQ[ch] = 1'b0;
    cyc();
    chk("s3_memr", bus.MEMR_N, !rd_mem);
    chk("s3_ior", bus.IOR_N, !rd_io);
    chk("s3_memw", bus.MEMW_N, !rd_io);
    chk("s3_iow", bus.IOW_N, !rd_mem);
    chk("s3_eop", bus.EOP_N, 1);
    chk("s3_dec", bus.decrement, 0);
    cyc();
    chk("s4_strobes", {bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N}, 4'b1111);
    chk("s4_dec", bus.decrement, 1);
    chk("s4_eop", bus.EOP_N, !tcv);
    chk("s4_dack", bus.DACK, dk);
    chk("s4_aen", bus.AEN, 1);
    cyc();
    chk("si_hrq", bus.HRQ, 0);
    chk("si_dack", bus.DACK, 0);
    chk("si_aen", bus.AEN, 0);
    chk("si_dec", bus.decrement, 0);
    chk("si_eop", bus.EOP_N, 1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    auto_hlda      = 1'b1;
    rst            = 1'b1;
    bus.DREQ       = 4'b0000;
    bus.HLDA       = 1'b0;
    bus.CS_N       = 1'b1;
    bus.commandReg = 8'h00;
    bus.xferType   = 8'b1010_1010;
    bus.maskReg    = 4'b0000;
    bus.tc         = 1'b0;
    #1;
    chk("rst_hrq", bus.HRQ, 0);
    chk("rst_dack", bus.DACK, 0);
    chk("rst_aen_adstb", {bus.AEN, bus.ADSTB}, 2'b00);
    chk("rst_strobes", {bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N, bus.EOP_N}, 5'b11111);
    chk("rst_dec", bus.decrement, 0);
    chk("rst_chan", bus.activeChannel, 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // ch0 read type, single transfer
    bus.DREQ = 4'b0001;
    xfer(2'd0, 2'b10, 1'b0, 1'b1);

    // fixed priority: ch1 before ch3
    bus.DREQ = 4'b1010;
    xfer(2'd1, 2'b10, 1'b0, 1'b1);
    xfer(2'd3, 2'b10, 1'b0, 1'b1);
    chk("fixed_dreq_left", bus.DREQ, 0);

    // rotating priority with all requests held
    bus.commandReg = 8'h10;
    bus.DREQ = 4'b1111;
    xfer(2'd0, 2'b10, 1'b0, 1'b0);
    xfer(2'd1, 2'b10, 1'b0, 1'b0);
    xfer(2'd2, 2'b10, 1'b0, 1'b0);
    xfer(2'd3, 2'b10, 1'b0, 1'b0);
    xfer(2'd0, 2'b10, 1'b0, 1'b0);
    bus.DREQ = 4'b0000;
    bus.commandReg = 8'h00;
    cyc();

    // masked request and disabled controller
    bus.maskReg = 4'b0100;
    bus.DREQ = 4'b0100;
    for (int i = 0; i < 3; i++) begin cyc(); chk("mask_hrq", bus.HRQ, 0); end
    bus.maskReg = 4'b0000;
    bus.commandReg = 8'h04;
    for (int i = 0; i < 3; i++) begin cyc(); chk("disable_hrq", bus.HRQ, 0); end
    bus.commandReg = 8'h00;
    bus.DREQ = 4'b0000;
    cyc();

    // write-type ch2 with terminal count
    bus.xferType = 8'b1001_1010;
    bus.tc = 1'b1;
    bus.DREQ = 4'b0100;
    xfer(2'd2, 2'b01, 1'b1, 1'b1);
    bus.tc = 1'b0;
    cyc();

    // HLDA dropped in S2
    bus.DREQ = 4'b0001;
    cyc();
    cyc();
    cyc();
    chk("ab_s2_dack", bus.DACK, 4'b0001);
    auto_hlda = 1'b0;
    bus.HLDA = 1'b0;
    bus.DREQ = 4'b0000;
    cyc();
    chk("ab_dack", bus.DACK, 0);
    chk("ab_aen_hrq", {bus.AEN, bus.HRQ}, 2'b00);
    chk("ab_strobes", {bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N}, 4'b1111);
    chk("ab_dec", bus.decrement, 0);
    cyc();
    chk("ab_dec2", bus.decrement, 0);

    // DREQ dropped in S0 before HLDA
    bus.DREQ = 4'b0001;
    cyc();
    chk("s0drop_hrq_up", bus.HRQ, 1);
    bus.DREQ = 4'b0000;
    cyc();
    chk("s0drop_hrq_down", bus.HRQ, 0);
    cyc();
    chk("s0drop_idle", bus.HRQ, 0);

    // programCondition
    bus.CS_N = 1'b0;
    #1;
    chk("pc_on", bus.programCondition, 1);
    bus.HLDA = 1'b1;
    #1;
    chk("pc_hlda", bus.programCondition, 0);
    bus.HLDA = 1'b0;
    bus.CS_N = 1'b1;
    #1;
    chk("pc_cs", bus.programCondition, 0);

    // reset asserted in the middle of S2
    auto_hlda = 1'b1;
    bus.DREQ = 4'b0001;
    cyc();
    cyc();
    cyc();
    chk("mid_s2_dack", bus.DACK, 4'b0001);
    chk("mid_s2_memr", bus.MEMR_N, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_dack", bus.DACK, 0);
    chk("mid_rst_aen", bus.AEN, 0);
    chk("mid_rst_memr", bus.MEMR_N, 1);
    chk("mid_rst_hrq", bus.HRQ, 0);
    bus.DREQ = 4'b0000;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("post_rst_hrq", bus.HRQ, 0);
    chk("post_rst_aen", bus.AEN, 0);
    chk("post_rst_dack", bus.DACK, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
